lin_map: RTL and testbench

- Registered 8-bit GF(2) linear basis-change block for the masked (DOM) AES S-box datapath.
- MATRIX_SEL=1 maps a byte from the AES polynomial basis into the S-box's internal tower-field basis, ahead of the inversion stage.
- MATRIX_SEL=0 applies the exact inverse mapping, back to the polynomial basis, after the inversion stage.
- Operates on one share; a masked design instantiates one copy per share, because the map is linear.

---
 rtl/lin_map.sv | 66 ++++++
 tb/tb_lin_map.sv | 133 +++++++++++++
 2 files changed

// File: rtl/lin_map.sv
// Registered GF(2) basis change for one share of the masked AES S-box.
// MATRIX_SEL=1 maps polynomial to tower basis, 0 maps back, anything else passes through.
module lin_map #(
  parameter int MATRIX_SEL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] DataInxDI,
  input  logic       ValidInxSI,
  output logic [7:0] DataOutxDO,
  output logic       ValidOutxSO
);

  logic [7:0] fwd_map;
  logic [7:0] inv_map;
  logic [7:0] data_d, data_q;
  logic       valid_d, valid_q;

  // Pure XOR networks only: no AND terms, so each share stays mask-independent.
  always_comb begin
    fwd_map[7] = DataInxDI[7] ^ DataInxDI[5];
    fwd_map[6] = DataInxDI[7] ^ DataInxDI[6] ^ DataInxDI[4] ^ DataInxDI[3] ^ DataInxDI[2] ^ DataInxDI[1];
    fwd_map[5] = DataInxDI[7] ^ DataInxDI[5] ^ DataInxDI[3] ^ DataInxDI[2];
    fwd_map[4] = DataInxDI[7] ^ DataInxDI[5] ^ DataInxDI[3] ^ DataInxDI[2] ^ DataInxDI[1];
    fwd_map[3] = DataInxDI[7] ^ DataInxDI[6] ^ DataInxDI[2] ^ DataInxDI[1];
    fwd_map[2] = DataInxDI[7] ^ DataInxDI[4] ^ DataInxDI[3] ^ DataInxDI[2] ^ DataInxDI[1];
    fwd_map[1] = DataInxDI[6] ^ DataInxDI[4] ^ DataInxDI[1];
    fwd_map[0] = DataInxDI[6] ^ DataInxDI[1] ^ DataInxDI[0];
  end

  always_comb begin
    inv_map[7] = DataInxDI[7] ^ DataInxDI[6] ^ DataInxDI[5] ^ DataInxDI[1];
    inv_map[6] = DataInxDI[6] ^ DataInxDI[2];
    inv_map[5] = DataInxDI[6] ^ DataInxDI[5] ^ DataInxDI[1];
    inv_map[4] = DataInxDI[6] ^ DataInxDI[5] ^ DataInxDI[4] ^ DataInxDI[2] ^ DataInxDI[1];
    inv_map[3] = DataInxDI[5] ^ DataInxDI[4] ^ DataInxDI[3] ^ DataInxDI[2] ^ DataInxDI[1];
    inv_map[2] = DataInxDI[7] ^ DataInxDI[4] ^ DataInxDI[3] ^ DataInxDI[2] ^ DataInxDI[1];
    inv_map[1] = DataInxDI[5] ^ DataInxDI[4];
    inv_map[0] = DataInxDI[6] ^ DataInxDI[5] ^ DataInxDI[4] ^ DataInxDI[2] ^ DataInxDI[0];
  end

  // Data loads every cycle; valid only qualifies it downstream.
  always_comb begin
    data_d  = DataInxDI;
    valid_d = ValidInxSI;
    if (MATRIX_SEL == 1) begin
      data_d = fwd_map;
    end else if (MATRIX_SEL == 0) begin
      data_d = inv_map;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign DataOutxDO  = data_q;
  assign ValidOutxSO = valid_q;

endmodule

// File: tb/tb_lin_map.sv
// Directed bench for lin_map: forward, inverse round trip and pass-through instances.
module tb_lin_map;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       vin;
  logic [7:0] fwd_out, inv_out, id_out;
  logic       fwd_vld, inv_vld, id_vld;
  int         total = 0;
  int         bad = 0;
  logic [7:0] prev;
  logic [7:0] a, b;
  logic [7:0] vdat [5];
  logic       vpat [5];

  always #5 clk = ~clk;

  lin_map #(.MATRIX_SEL(1)) u_fwd (
    .clk(clk), .rst(rst), .DataInxDI(din), .ValidInxSI(vin),
    .DataOutxDO(fwd_out), .ValidOutxSO(fwd_vld)
  );

  lin_map #(.MATRIX_SEL(0)) u_inv (
    .clk(clk), .rst(rst), .DataInxDI(fwd_out), .ValidInxSI(fwd_vld),
    .DataOutxDO(inv_out), .ValidOutxSO(inv_vld)
  );

  lin_map #(.MATRIX_SEL(2)) u_id (
    .clk(clk), .rst(rst), .DataInxDI(din), .ValidInxSI(vin),
    .DataOutxDO(id_out), .ValidOutxSO(id_vld)
  );

  // Reference built from the image of each basis vector (columns of M).
  function automatic logic [7:0] col_map(input logic [7:0] x);
    logic [7:0] cols [8];
    logic [7:0] r;
    cols[0] = 8'h01; cols[1] = 8'h5F; cols[2] = 8'h7C; cols[3] = 8'h74;
    cols[4] = 8'h46; cols[5] = 8'hB0; cols[6] = 8'h4B; cols[7] = 8'hFC;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (x[k]) r = r ^ cols[k];
    end
    return r;
  endfunction

  task automatic apply_stimulus(input logic r, input logic [7:0] d, input logic v);
    rst = r;
    din = d;
    vin = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 8'hFF;
    vin = 1'b1;

    for (int c = 0; c < 2; c++) begin
      apply_stimulus(1'b1, 8'hFF, 1'b1);
      check_output("rst_fwd_data", fwd_out, 8'h00);
      check_output("rst_fwd_valid", {7'd0, fwd_vld}, 8'h00);
      check_output("rst_inv_data", inv_out, 8'h00);
      check_output("rst_inv_valid", {7'd0, inv_vld}, 8'h00);
    end

    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("basis_00", fwd_out, 8'h00);
    check_output("basis_valid", {7'd0, fwd_vld}, 8'h01);
    apply_stimulus(1'b0, 8'h01, 1'b1);
    check_output("basis_01", fwd_out, 8'h01);
    apply_stimulus(1'b0, 8'h02, 1'b1);
    check_output("basis_02", fwd_out, 8'h5F);
    apply_stimulus(1'b0, 8'h80, 1'b1);
    check_output("basis_80", fwd_out, 8'hFC);
    apply_stimulus(1'b0, 8'h82, 1'b1);
    check_output("linear_82", fwd_out, 8'hA3);
    prev = 8'h82;

    // Full sweep: forward against the column model, round trip one cycle behind.
    for (int i = 0; i < 256; i++) begin
      apply_stimulus(1'b0, 8'(i), 1'b1);
      check_output("sweep_fwd", fwd_out, col_map(8'(i)));
      check_output("sweep_roundtrip", inv_out, prev);
      check_output("sweep_identity", id_out, 8'(i));
      prev = 8'(i);
    end
    check_output("roundtrip_valid", {7'd0, inv_vld}, 8'h01);

    for (int p = 0; p < 8; p++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      apply_stimulus(1'b0, a ^ b, 1'b1);
      check_output("linear_pair", fwd_out, col_map(a) ^ col_map(b));
    end

    vdat[0] = 8'h11; vdat[1] = 8'h22; vdat[2] = 8'h33; vdat[3] = 8'h44; vdat[4] = 8'h55;
    vpat[0] = 1'b1;  vpat[1] = 1'b0;  vpat[2] = 1'b1;  vpat[3] = 1'b1;  vpat[4] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      apply_stimulus(1'b0, vdat[j], vpat[j]);
      check_output("valid_pipe", {7'd0, fwd_vld}, {7'd0, vpat[j]});
      check_output("valid_pipe_data", fwd_out, col_map(vdat[j]));
    end

    apply_stimulus(1'b0, 8'h10, 1'b1);
    check_output("mid_pre", fwd_out, col_map(8'h10));
    apply_stimulus(1'b1, 8'h20, 1'b1);
    check_output("mid_rst_data", fwd_out, 8'h00);
    check_output("mid_rst_valid", {7'd0, fwd_vld}, 8'h00);
    check_output("mid_rst_inv_valid", {7'd0, inv_vld}, 8'h00);
    apply_stimulus(1'b0, 8'h30, 1'b1);
    check_output("mid_resume_data", fwd_out, col_map(8'h30));
    check_output("mid_resume_valid", {7'd0, fwd_vld}, 8'h01);
    check_output("mid_inv_after", inv_out, 8'h00);
    check_output("mid_inv_after_valid", {7'd0, inv_vld}, 8'h00);
    apply_stimulus(1'b0, 8'h40, 1'b1);
    check_output("mid_inv_resume", inv_out, 8'h30);
    check_output("mid_inv_resume_valid", {7'd0, inv_vld}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
